lrf_commit: RTL and testbench
=============================

Name: lrf_commit

Overview:
- In-order dual-retire commit queue that acts as the writer for the logic register file's two write ports.
- Dispatch allocates up to two entries per cycle in program order. Execution writebacks mark entries done by tag.
- The head retires up to two consecutive done entries per cycle and drives wen0/wen1 (older on way0, younger on way1).
- hi/lo destinations are absorbed into internal registers, which are exported as hi/lo.

Parameters:
- DEPTH, 8, number of queue entries; power of two, at least 4.
- TAG_W, 3, log2(DEPTH); width of tags and pointers.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- flush  in  1  discard all entries
- alloc_req0  in  1  allocate the older instruction
- alloc_dst0  in  6  destination of the older instruction
- alloc_req1  in  1  allocate the younger instruction; honoured only together with alloc_req0
- alloc_dst1  in  6  destination of the younger instruction
- alloc_ready  out  1  at least 2 entries free
- alloc_tag0  out  TAG_W  tag given to slot0 (equals tail)
- alloc_tag1  out  TAG_W  tag given to slot1 (equals tail+1 mod DEPTH)
- wb_valid0  in  1  writeback way0 valid
- wb_tag0  in  TAG_W  writeback way0 tag
- wb_data0  in  32  writeback way0 result
- wb_valid1  in  1  writeback way1 valid
- wb_tag1  in  TAG_W  writeback way1 tag
- wb_data1  in  32  writeback way1 result
- wen0  out  1  register file write enable, way0 (older)
- wr_addr0  out  5  register file write address, way0
- wr_data0  out  32  register file write data, way0
- wen1  out  1  register file write enable, way1 (younger)
- wr_addr1  out  5  register file write address, way1
- wr_data1  out  32  register file write data, way1
- hi  out  32  architectural hi
- lo  out  32  architectural lo
- empty  out  1  queue holds no entries
- retire_cnt  out  2  entries retiring this cycle

Behaviour:
- Reset: resetn is synchronous, active-low, clock clk. Reset sets head=tail=0, count=0, all entry valid/done=0, hi=lo=0. Resulting outputs: wen0=wen1=0, wr_addr*=0, wr_data*=0, empty=1, alloc_ready=1, retire_cnt=0.
- Destination encoding:
  - 0 = no destination.
  - 1..31 = GPR.
  - 6'd33 (bit5 set, bit0=1) = hi.
  - 6'd34 (bit5 set, bit0=0) = lo.
  - Other values with bit5 set are treated as hi when bit0=1, otherwise lo.
- Allocation:
  - Accepted at the clock edge when alloc_ready=1, flush=0 and alloc_req0=1.
  - Writes valid=1, done=0 and the destination at tail (and tail+1 if alloc_req1).
  - tail advances by 1 or 2, wrapping mod DEPTH.
  - alloc_req1 without alloc_req0 is ignored. Requests while alloc_ready=0 are dropped; the requester must hold them.
- Writeback: at the edge, a valid writeback to a valid entry sets done=1 and stores the data. Writeback to an invalid tag is ignored. Both ways carrying the same tag is illegal.
- Retire, combinational from state in the cycle after the entry became done:
  - slot0 retires if head is valid and done.
  - slot1 retires if slot0 retires and head+1 is valid and done.
  - GPR destination: wen=1, wr_addr=dst[4:0], wr_data=entry data.
  - Destination 0 or hi/lo: wen=0, address and data are don't-care but driven 0.
  - Latency: writeback edge E → wen high in cycle E..E+1 → register file and hi/lo updated at edge E+1.
  - head and count update at the same edge.
- Same GPR address on both ways is allowed and driven as-is. The register file gives way1 (the younger instruction) priority, so the younger result wins.
- hi/lo update at the retire edge. If both retiring entries target the same one, the younger value wins.
- Simultaneous events in one cycle:
  - Allocation, writeback and retire all apply.
  - count_next = count + allocated − retired.
  - alloc_ready is computed from the current count only: DEPTH − count ≥ 2.
  - A writeback can target the current head, which then retires in the next cycle.
- Flush has priority over alloc, writeback and retire in its cycle:
  - wen0=wen1=0, retire_cnt=0.
  - At the edge: all entries invalid, head=tail=0, count=0.
  - hi/lo are unchanged.
- Wrap-around: pointers are TAG_W bits and count is TAG_W+1 bits. The full state is count=DEPTH.

Decomposition:
- Package lrf_commit_pkg:
  - DEPTH default and TAG_W.
  - DST_NONE=6'd0, DST_HI=6'd33, DST_LO=6'd34.
  - Struct commit_entry_t {valid, done, dst[5:0], data[31:0]}.
  - Function is_hilo(dst).
- One sub-module: hilo_reg, holding the hi/lo registers with two prioritised update ports, younger wins.

Test Plan:
1. Reset: hold resetn=0 for 2 cycles → empty=1, alloc_ready=1, hi=lo=0, wen0=wen1=0, retire_cnt=0.
2. Out-of-order completion:
   - Allocate dst 5 and 6 (tags 0 and 1), then wb tag1=0x22 → no retire.
   - Next cycle wb tag0=0x11 → following cycle wen0=1 addr5 0x11, wen1=1 addr6 0x22, retire_cnt=2, empty=1 after the edge.
3. Same address: allocate dst 7 and 7, wb 0xA and 0xB → wen0 addr7 0xA, wen1 addr7 0xB in the same cycle.
4. hi/lo and no-destination:
   - Allocate 33 and 34, wb 0xAAAA and 0x5555 → wen0=wen1=0, next cycle hi=0xAAAA, lo=0x5555.
   - Allocate dst 0, wb → retire_cnt=1, wen0=0.
5. Full and wrap-around:
   - Four dual allocations → count=8, alloc_ready=0; an alloc request is dropped.
   - Retire 2 → alloc_ready=1, next tags are 0 and 1. Run 20 random-order completions; retired addresses come out in allocation order.
6. Flush: with 3 done entries pending, assert flush → wen0=wen1=0 that cycle, empty=1 next cycle, next alloc_tag0=0, hi/lo unchanged.

Source files
------------

// File: rtl/lrf_commit_pkg.sv
// lrf_commit_pkg
//   Shared types and constants for the logic-register-file commit queue.
//   - DEPTH_DEF / TAG_W_DEF : default queue depth and tag/pointer width
//   - DST_* : destination encodings (0 = none, 1..31 = GPR, bit5 set = hi/lo)
//   - commit_entry_t : one queue entry
//   - is_hilo / is_gpr / hilo_is_hi : destination decode helpers
package lrf_commit_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int TAG_W_DEF = 3;

    localparam logic [5:0] DST_NONE = 6'd0;
    localparam logic [5:0] DST_HI   = 6'd33;
    localparam logic [5:0] DST_LO   = 6'd34;

    // The bit shared by the hi and lo encodings marks every hi/lo destination.
    localparam logic [5:0] HILO_MASK = DST_HI & DST_LO;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic [5:0]  dst;
        logic [31:0] data;
    } commit_entry_t;

    function automatic logic is_hilo(input logic [5:0] dst);
        return (dst & HILO_MASK) != DST_NONE;
    endfunction

    function automatic logic is_gpr(input logic [5:0] dst);
        return !is_hilo(dst) && (dst != DST_NONE);
    endfunction

    // Any hi/lo encoding with bit0 set selects hi, otherwise lo.
    function automatic logic hilo_is_hi(input logic [5:0] dst);
        return dst[0] == DST_HI[0];
    endfunction

endpackage

// File: rtl/lrf_commit_hilo_reg.sv
// lrf_commit_hilo_reg
//   Architectural hi/lo registers with two update ports.
//   Port 1 carries the younger retiring instruction and wins when both
//   ports target the same register in one cycle.
//   - clk, resetn         : clock, synchronous active-low reset (clears hi/lo)
//   - upd0_en/hi/data     : older update (hi selects hi, else lo)
//   - upd1_en/hi/data     : younger update
//   - hi, lo              : current register values
module lrf_commit_hilo_reg (
    input  logic        clk,
    input  logic        resetn,
    input  logic        upd0_en,
    input  logic        upd0_hi,
    input  logic [31:0] upd0_data,
    input  logic        upd1_en,
    input  logic        upd1_hi,
    input  logic [31:0] upd1_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (upd1_en && upd1_hi) begin
                hi <= upd1_data;
            end else if (upd0_en && upd0_hi) begin
                hi <= upd0_data;
            end
            if (upd1_en && !upd1_hi) begin
                lo <= upd1_data;
            end else if (upd0_en && !upd0_hi) begin
                lo <= upd0_data;
            end
        end
    end

endmodule

// File: rtl/lrf_commit.sv
// lrf_commit
//   In-order dual-retire commit queue driving the two register-file write
//   ports. Dispatch allocates up to two entries per cycle at the tail,
//   writebacks mark entries done by tag, and the head retires up to two
//   consecutive done entries per cycle (older on way0, younger on way1).
//   hi/lo destinations are absorbed into an internal hi/lo register pair.
//   Ports:
//   - clk, resetn, flush        : clock, sync active-low reset, discard all
//   - alloc_req0/1, alloc_dst0/1: allocation requests (req1 needs req0)
//   - alloc_ready, alloc_tag0/1 : at least two free entries; tags handed out
//   - wb_valid/tag/data 0/1     : execution writebacks
//   - wen/wr_addr/wr_data 0/1   : register-file write ports
//   - hi, lo                    : architectural hi/lo
//   - empty, retire_cnt         : queue empty; entries retiring this cycle
//
// Allocation handshake: a request is accepted at the clock edge when
// alloc_ready=1, flush=0 and alloc_req0=1. alloc_ready depends only on the
// current occupancy, never on the request itself; a request seen while
// alloc_ready=0 is dropped and must be held by the requester until accepted.
module lrf_commit
    import lrf_commit_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             alloc_req0,
    input  logic [5:0]       alloc_dst0,
    input  logic             alloc_req1,
    input  logic [5:0]       alloc_dst1,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag0,
    output logic [TAG_W-1:0] alloc_tag1,
    input  logic             wb_valid0,
    input  logic [TAG_W-1:0] wb_tag0,
    input  logic [31:0]      wb_data0,
    input  logic             wb_valid1,
    input  logic [TAG_W-1:0] wb_tag1,
    input  logic [31:0]      wb_data1,
    output logic             wen0,
    output logic [4:0]       wr_addr0,
    output logic [31:0]      wr_data0,
    output logic             wen1,
    output logic [4:0]       wr_addr1,
    output logic [31:0]      wr_data1,
    output logic [31:0]      hi,
    output logic [31:0]      lo,
    output logic             empty,
    output logic [1:0]       retire_cnt
);

    localparam logic [TAG_W:0] ALLOC_LIMIT = (TAG_W+1)'(DEPTH - 2);

    commit_entry_t    q [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic [TAG_W-1:0] head_p1;
    logic [TAG_W-1:0] tail_p1;
    commit_entry_t    e0;
    commit_entry_t    e1;
    logic             ret0;
    logic             ret1;
    logic             do_alloc;
    logic [TAG_W:0]   alloc_n;
    logic [TAG_W:0]   retire_n;

    assign head_p1 = head + TAG_W'(1);
    assign tail_p1 = tail + TAG_W'(1);
    assign e0      = q[head];
    assign e1      = q[head_p1];

    // Flush suppresses retirement in its own cycle.
    assign ret0 = !flush && e0.valid && e0.done;
    assign ret1 = ret0 && e1.valid && e1.done;

    assign alloc_ready = (count <= ALLOC_LIMIT);
    assign do_alloc    = alloc_ready && !flush && alloc_req0;
    assign alloc_tag0  = tail;
    assign alloc_tag1  = tail_p1;
    assign empty       = (count == '0);
    assign retire_cnt  = {ret1, ret0 & ~ret1};
    assign retire_n    = (TAG_W+1)'(retire_cnt);

    always_comb begin
        alloc_n = '0;
        if (do_alloc) begin
            alloc_n = alloc_req1 ? (TAG_W+1)'(2) : (TAG_W+1)'(1);
        end
    end

    // Register-file ports: only GPR destinations write; otherwise drive 0.
    assign wen0     = ret0 && is_gpr(e0.dst);
    assign wr_addr0 = wen0 ? e0.dst[4:0] : '0;
    assign wr_data0 = wen0 ? e0.data : '0;
    assign wen1     = ret1 && is_gpr(e1.dst);
    assign wr_addr1 = wen1 ? e1.dst[4:0] : '0;
    assign wr_data1 = wen1 ? e1.data : '0;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wb_valid0 && q[wb_tag0].valid) begin
                q[wb_tag0].done <= 1'b1;
                q[wb_tag0].data <= wb_data0;
            end
            if (wb_valid1 && q[wb_tag1].valid) begin
                q[wb_tag1].done <= 1'b1;
                q[wb_tag1].data <= wb_data1;
            end
            if (ret0) begin
                q[head].valid <= 1'b0;
                q[head].done  <= 1'b0;
            end
            if (ret1) begin
                q[head_p1].valid <= 1'b0;
                q[head_p1].done  <= 1'b0;
            end
            // Allocated slots are free, so they never collide with the
            // head entries retiring or the valid entries written back.
            if (do_alloc) begin
                q[tail] <= '{valid: 1'b1, done: 1'b0, dst: alloc_dst0, data: '0};
                if (alloc_req1) begin
                    q[tail_p1] <= '{valid: 1'b1, done: 1'b0, dst: alloc_dst1, data: '0};
                end
            end
            head  <= head + retire_n[TAG_W-1:0];
            tail  <= tail + alloc_n[TAG_W-1:0];
            count <= count + alloc_n - retire_n;
        end
    end

    lrf_commit_hilo_reg u_hilo (
        .clk       (clk),
        .resetn    (resetn),
        .upd0_en   (ret0 && is_hilo(e0.dst)),
        .upd0_hi   (hilo_is_hi(e0.dst)),
        .upd0_data (e0.data),
        .upd1_en   (ret1 && is_hilo(e1.dst)),
        .upd1_hi   (hilo_is_hi(e1.dst)),
        .upd1_data (e1.data),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_lrf_commit.sv
// tb_lrf_commit
//   Directed bench for lrf_commit with a small in-order queue model and an
//   expected-retire queue used in the full/wrap-around and random phases.
module tb_lrf_commit;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        alloc_req0;
    logic [5:0]  alloc_dst0;
    logic        alloc_req1;
    logic [5:0]  alloc_dst1;
    logic        alloc_ready;
    logic [2:0]  alloc_tag0;
    logic [2:0]  alloc_tag1;
    logic        wb_valid0;
    logic [2:0]  wb_tag0;
    logic [31:0] wb_data0;
    logic        wb_valid1;
    logic [2:0]  wb_tag1;
    logic [31:0] wb_data1;
    logic        wen0;
    logic [4:0]  wr_addr0;
    logic [31:0] wr_data0;
    logic        wen1;
    logic [4:0]  wr_addr1;
    logic [31:0] wr_data1;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        empty;
    logic [1:0]  retire_cnt;

    lrf_commit #(.DEPTH(8), .TAG_W(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .alloc_req0 (alloc_req0),
        .alloc_dst0 (alloc_dst0),
        .alloc_req1 (alloc_req1),
        .alloc_dst1 (alloc_dst1),
        .alloc_ready(alloc_ready),
        .alloc_tag0 (alloc_tag0),
        .alloc_tag1 (alloc_tag1),
        .wb_valid0  (wb_valid0),
        .wb_tag0    (wb_tag0),
        .wb_data0   (wb_data0),
        .wb_valid1  (wb_valid1),
        .wb_tag1    (wb_tag1),
        .wb_data1   (wb_data1),
        .wen0       (wen0),
        .wr_addr0   (wr_addr0),
        .wr_data0   (wr_data0),
        .wen1       (wen1),
        .wr_addr1   (wr_addr1),
        .wr_data1   (wr_data1),
        .hi         (hi),
        .lo         (lo),
        .empty      (empty),
        .retire_cnt (retire_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / model ----------------
    int vectors     = 0;
    int miscompares = 0;

    logic        mvalid [8];
    logic        mdone  [8];
    logic [5:0]  mdst   [8];
    logic [31:0] mdata  [8];
    logic [2:0]  mh;
    logic [2:0]  mt;
    int          mcnt;
    int          seq;
    logic        sb_on;
    logic [36:0] exp_q [$];
    logic [2:0]  pend_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic alloc_slot(input logic [2:0] t, input logic [5:0] d);
        mvalid[t] = 1'b1;
        mdone[t]  = 1'b0;
        mdst[t]   = d;
        mdata[t]  = 32'hC000_0000 + 32'(seq);
        seq++;
        if (sb_on) exp_q.push_back({d[4:0], mdata[t]});
    endtask

    // Applies the currently driven inputs to the reference queue model.
    task automatic model_step();
        logic [2:0] h1;
        logic       r0;
        logic       r1;
        int         na;
        if (!resetn || flush) begin
            for (int i = 0; i < 8; i++) begin
                mvalid[i] = 1'b0;
                mdone[i]  = 1'b0;
            end
            mh = '0;
            mt = '0;
            mcnt = 0;
            exp_q.delete();
        end else begin
            h1 = mh + 3'd1;
            r0 = mvalid[mh] && mdone[mh];
            r1 = r0 && mvalid[h1] && mdone[h1];
            if (r0) begin mvalid[mh] = 1'b0; mdone[mh] = 1'b0; end
            if (r1) begin mvalid[h1] = 1'b0; mdone[h1] = 1'b0; end
            if (wb_valid0 && mvalid[wb_tag0]) mdone[wb_tag0] = 1'b1;
            if (wb_valid1 && mvalid[wb_tag1]) mdone[wb_tag1] = 1'b1;
            na = 0;
            if (mcnt <= 6 && alloc_req0) begin
                alloc_slot(mt, alloc_dst0);
                na = 1;
                if (alloc_req1) begin
                    alloc_slot(mt + 3'd1, alloc_dst1);
                    na = 2;
                end
            end
            mh   = mh + 3'(int'(r0) + int'(r1));
            mt   = mt + 3'(na);
            mcnt = mcnt + na - int'(r0) - int'(r1);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard check of this cycle's retirement against the model.
    task automatic sb_retire_check(input string tag);
        logic [2:0]  h1;
        int          n;
        logic [36:0] e;
        h1 = mh + 3'd1;
        n = (mvalid[mh] && mdone[mh]) ? ((mvalid[h1] && mdone[h1]) ? 2 : 1) : 0;
        chk({tag, "_rcnt"}, 64'(retire_cnt), 64'(n));
        if (n >= 1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            chk({tag, "_way0"}, {26'd0, wen0, wr_addr0, wr_data0}, {26'd0, 1'b1, e});
        end
        if (n == 2) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            chk({tag, "_way1"}, {26'd0, wen1, wr_addr1, wr_data1}, {26'd0, 1'b1, e});
        end
    endtask

    task automatic idle_inputs();
        flush = 0; alloc_req0 = 0; alloc_req1 = 0; alloc_dst0 = '0; alloc_dst1 = '0;
        wb_valid0 = 0; wb_tag0 = '0; wb_data0 = '0;
        wb_valid1 = 0; wb_tag1 = '0; wb_data1 = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          comps;
        int          idx;
        logic [2:0]  t;
        seq = 0;
        sb_on = 1'b0;
        mh = '0; mt = '0; mcnt = 0;
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0; mdone[i] = 1'b0; mdst[i] = '0; mdata[i] = '0;
        end
        idle_inputs();

        // 1. reset
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(alloc_ready), 64'd1);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_wen", {62'd0, wen0, wen1}, 64'd0);
        chk("rst_rcnt", 64'(retire_cnt), 64'd0);
        chk("rst_addr_data", {wr_addr0, wr_addr1, wr_data0[15:0], wr_data1[15:0]}, 64'd0);

        // 2. out-of-order completion
        alloc_req0 = 1; alloc_dst0 = 6'd5; alloc_req1 = 1; alloc_dst1 = 6'd6;
        chk("ooo_tag0", 64'(alloc_tag0), 64'd0);
        chk("ooo_tag1", 64'(alloc_tag1), 64'd1);
        cyc();
        idle_inputs();
        chk("ooo_notempty", 64'(empty), 64'd0);
        wb_valid1 = 1; wb_tag1 = 3'd1; wb_data1 = 32'h22;
        chk("ooo_rcnt_a", 64'(retire_cnt), 64'd0);
        cyc();
        idle_inputs();
        chk("ooo_rcnt_b", 64'(retire_cnt), 64'd0);
        chk("ooo_wen_b", {62'd0, wen0, wen1}, 64'd0);
        wb_valid0 = 1; wb_tag0 = 3'd0; wb_data0 = 32'h11;
        cyc();
        idle_inputs();
        chk("ooo_way0", {wen0, wr_addr0, wr_data0}, {1'b1, 5'd5, 32'h11});
        chk("ooo_way1", {wen1, wr_addr1, wr_data1}, {1'b1, 5'd6, 32'h22});
        chk("ooo_rcnt_c", 64'(retire_cnt), 64'd2);
        cyc();
        chk("ooo_empty", 64'(empty), 64'd1);
        chk("ooo_wen_d", {62'd0, wen0, wen1}, 64'd0);

        // 3. same GPR on both ways
        alloc_req0 = 1; alloc_dst0 = 6'd7; alloc_req1 = 1; alloc_dst1 = 6'd7;
        chk("same_tag0", 64'(alloc_tag0), 64'd2);
        cyc();
        idle_inputs();
        wb_valid0 = 1; wb_tag0 = 3'd2; wb_data0 = 32'hA;
        wb_valid1 = 1; wb_tag1 = 3'd3; wb_data1 = 32'hB;
        cyc();
        idle_inputs();
        chk("same_way0", {wen0, wr_addr0, wr_data0}, {1'b1, 5'd7, 32'hA});
        chk("same_way1", {wen1, wr_addr1, wr_data1}, {1'b1, 5'd7, 32'hB});
        cyc();

        // 4. hi/lo and no destination
        alloc_req0 = 1; alloc_dst0 = 6'd33; alloc_req1 = 1; alloc_dst1 = 6'd34;
        chk("hilo_tag0", 64'(alloc_tag0), 64'd4);
        cyc();
        idle_inputs();
        wb_valid0 = 1; wb_tag0 = 3'd4; wb_data0 = 32'hAAAA;
        wb_valid1 = 1; wb_tag1 = 3'd5; wb_data1 = 32'h5555;
        cyc();
        idle_inputs();
        chk("hilo_wen", {62'd0, wen0, wen1}, 64'd0);
        chk("hilo_rcnt", 64'(retire_cnt), 64'd2);
        chk("hilo_addr_zero", {wr_addr0, wr_addr1, wr_data0[15:0], wr_data1[15:0]}, 64'd0);
        chk("hilo_hi_before", 64'(hi), 64'd0);
        cyc();
        chk("hilo_hi", 64'(hi), 64'hAAAA);
        chk("hilo_lo", 64'(lo), 64'h5555);
        alloc_req0 = 1; alloc_dst0 = 6'd0;
        chk("none_tag0", 64'(alloc_tag0), 64'd6);
        cyc();
        idle_inputs();
        wb_valid0 = 1; wb_tag0 = 3'd6; wb_data0 = 32'h99;
        cyc();
        idle_inputs();
        chk("none_rcnt", 64'(retire_cnt), 64'd1);
        chk("none_way0", {wen0, wr_addr0, wr_data0}, 38'd0);
        cyc();
        chk("none_empty", 64'(empty), 64'd1);
        chk("none_tag_next", 64'(alloc_tag0), 64'd7);

        // 5. full and wrap-around
        flush = 1;
        cyc();
        idle_inputs();
        sb_on = 1'b1;
        pend_q.delete();
        chk("flush0_empty", 64'(empty), 64'd1);
        chk("flush0_tag0", 64'(alloc_tag0), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("full_ready", 64'(alloc_ready), 64'd1);
            alloc_req0 = 1; alloc_dst0 = 6'(10 + 2 * i);
            alloc_req1 = 1; alloc_dst1 = 6'(11 + 2 * i);
            pend_q.push_back(3'(2 * i));
            pend_q.push_back(3'(2 * i + 1));
            cyc();
        end
        idle_inputs();
        chk("full_ready0", 64'(alloc_ready), 64'd0);
        chk("full_tag0", 64'(alloc_tag0), 64'd0);
        alloc_req0 = 1; alloc_dst0 = 6'd20;
        cyc();
        idle_inputs();
        chk("full_drop_tag0", 64'(alloc_tag0), 64'd0);
        chk("full_drop_ready", 64'(alloc_ready), 64'd0);
        chk("full_drop_rcnt", 64'(retire_cnt), 64'd0);
        void'(pend_q.pop_front());
        void'(pend_q.pop_front());
        wb_valid0 = 1; wb_tag0 = 3'd0; wb_data0 = mdata[0];
        wb_valid1 = 1; wb_tag1 = 3'd1; wb_data1 = mdata[1];
        cyc();
        idle_inputs();
        sb_retire_check("full_ret");
        chk("full_ret_ready", 64'(alloc_ready), 64'd0);
        cyc();
        chk("wrap_ready", 64'(alloc_ready), 64'd1);
        chk("wrap_tag0", 64'(alloc_tag0), 64'd0);
        chk("wrap_tag1", 64'(alloc_tag1), 64'd1);

        // random-order completions with continued allocation
        comps = 0;
        for (int c = 0; c < 300 && comps < 20; c++) begin
            sb_retire_check("rnd");
            chk("rnd_tag0", 64'(alloc_tag0), 64'(mt));
            chk("rnd_ready", 64'(alloc_ready), 64'(mcnt <= 6));
            idle_inputs();
            if (pend_q.size() > 0) begin
                idx = $urandom_range(0, pend_q.size() - 1);
                t = pend_q[idx];
                pend_q.delete(idx);
                wb_valid0 = 1; wb_tag0 = t; wb_data0 = mdata[t];
                comps++;
            end
            if (mcnt <= 6) begin
                alloc_req0 = 1; alloc_dst0 = 6'($urandom_range(1, 31));
                alloc_req1 = 1; alloc_dst1 = 6'($urandom_range(1, 31));
                pend_q.push_back(mt);
                pend_q.push_back(mt + 3'd1);
            end
            cyc();
        end
        idle_inputs();
        chk("rnd_completions", 64'(comps), 64'd20);

        // 6. flush with done entries pending
        flush = 1;
        cyc();
        idle_inputs();
        sb_on = 1'b0;
        alloc_req0 = 1; alloc_dst0 = 6'd34; alloc_req1 = 1; alloc_dst1 = 6'd21;
        cyc();
        idle_inputs();
        alloc_req0 = 1; alloc_dst0 = 6'd22;
        cyc();
        idle_inputs();
        wb_valid0 = 1; wb_tag0 = 3'd1; wb_data0 = 32'h1;
        wb_valid1 = 1; wb_tag1 = 3'd2; wb_data1 = 32'h2;
        cyc();
        idle_inputs();
        wb_valid0 = 1; wb_tag0 = 3'd0; wb_data0 = 32'hBEEF;
        cyc();
        idle_inputs();
        flush = 1;
        #1;
        chk("flush_wen", {62'd0, wen0, wen1}, 64'd0);
        chk("flush_rcnt", 64'(retire_cnt), 64'd0);
        cyc();
        idle_inputs();
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_tag0", 64'(alloc_tag0), 64'd0);
        chk("flush_hi", 64'(hi), 64'hAAAA);
        chk("flush_lo", 64'(lo), 64'h5555);
        chk("flush_wen_after", {62'd0, wen0, wen1}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
